// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control unit.
// Registered FSM state with purely combinational control outputs.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   opcode, funct       - IR[31:26] / IR[5:0], stable from DECODE onward
//   alu_zero, mem_ready - ALU zero flag, memory completion strobe
//   pc_we, pc_src       - PC write enable / source (0 ALU, 1 ALUOut, 2 jump)
//   ir_we               - IR write enable
//   mem_req, mem_we,
//   mem_size,
//   mem_unsigned        - memory request, store flag, size (0 B/1 H/2 W), zero-extend
//   alu_src_a/b, imm_zext, alu_op - ALU operand selects and operation
//   reg_we, reg_dst,
//   mem_to_reg          - register file write controls
//   illegal             - one-cycle pulse on unsupported opcode/funct
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [3:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    // Opcode / funct encodings
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ   = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI   = 6'h0F, OP_LB    = 6'h20,
                           OP_LH    = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
                           OP_LHU   = 6'h25, OP_SB    = 6'h28, OP_SH    = 6'h29,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                           FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                           FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                           FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;
    // ALU operation codes; ADDU is zero so the idle default is all-zero
    localparam logic [3:0] ALU_ADDU = 4'd0, ALU_SUBU = 4'd1, ALU_AND = 4'd2,
                           ALU_OR   = 4'd3, ALU_XOR  = 4'd4, ALU_NOR = 4'd5,
                           ALU_SLT  = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8,
                           ALU_SRL  = 4'd9, ALU_SRA  = 4'd10, ALU_LUI = 4'd11;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    state_t state_q, state_d;

    // Instruction decode shared by next-state and output logic
    logic       r_ok, i_ok, is_load, is_store, is_branch, is_jump;
    logic [3:0] r_alu, i_alu;
    logic       i_zext, ls_uns;
    logic [1:0] ls_size;

    always_comb begin
        r_ok = 1'b1;
        r_alu = ALU_ADDU;
        case (funct)
            FN_SLL, FN_SLLV: r_alu = ALU_SLL;
            FN_SRL, FN_SRLV: r_alu = ALU_SRL;
            FN_SRA, FN_SRAV: r_alu = ALU_SRA;
            FN_ADDU:         r_alu = ALU_ADDU;
            FN_SUBU:         r_alu = ALU_SUBU;
            FN_AND:          r_alu = ALU_AND;
            FN_OR:           r_alu = ALU_OR;
            FN_XOR:          r_alu = ALU_XOR;
            FN_NOR:          r_alu = ALU_NOR;
            FN_SLT:          r_alu = ALU_SLT;
            FN_SLTU:         r_alu = ALU_SLTU;
            default:         r_ok  = 1'b0;
        endcase
        if (opcode != OP_RTYPE) r_ok = 1'b0;

        i_ok = 1'b1;
        i_alu = ALU_ADDU;
        i_zext = 1'b0;
        case (opcode)
            OP_ADDIU: i_alu = ALU_ADDU;
            OP_SLTI:  i_alu = ALU_SLT;
            OP_SLTIU: i_alu = ALU_SLTU;
            OP_ANDI:  begin i_alu = ALU_AND; i_zext = 1'b1; end
            OP_ORI:   begin i_alu = ALU_OR;  i_zext = 1'b1; end
            OP_XORI:  begin i_alu = ALU_XOR; i_zext = 1'b1; end
            OP_LUI:   begin i_alu = ALU_LUI; i_zext = 1'b1; end
            default:  i_ok = 1'b0;
        endcase

        is_load  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                   (opcode == OP_LBU) || (opcode == OP_LHU);
        is_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump  = (opcode == OP_J);
        ls_uns   = (opcode == OP_LBU) || (opcode == OP_LHU);
        case (opcode)
            OP_LB, OP_LBU, OP_SB: ls_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: ls_size = 2'd1;
            default:              ls_size = 2'd2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (r_ok)                       state_d = S_EXEC_R;
                else if (is_load || is_store)   state_d = S_MEM_ADDR;
                else if (i_ok)                  state_d = S_EXEC_I;
                else if (is_branch)             state_d = S_BRANCH;
                else if (is_jump)               state_d = S_JUMP;
                else                            state_d = S_FETCH;
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we = 1'b0;  pc_src = 2'd0;  ir_we = 1'b0;
        mem_req = 1'b0;  mem_we = 1'b0;  mem_size = 2'd0;  mem_unsigned = 1'b0;
        alu_src_a = 1'b0;  alu_src_b = 2'd0;  imm_zext = 1'b0;  alu_op = ALU_ADDU;
        reg_we = 1'b0;  reg_dst = 1'b0;  mem_to_reg = 1'b0;  illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;  mem_size = 2'd2;  alu_src_b = 2'd1;
                ir_we = mem_ready;  pc_we = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut here
                alu_src_b = 2'd3;
                illegal = !(r_ok || i_ok || is_load || is_store || is_branch || is_jump);
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;  alu_op = r_alu;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;  alu_src_b = 2'd2;  alu_op = i_alu;  imm_zext = i_zext;
            end
            S_WB_R:     begin reg_we = 1'b1;  reg_dst = 1'b1; end
            S_WB_I:     reg_we = 1'b1;
            S_MEM_ADDR: begin alu_src_a = 1'b1;  alu_src_b = 2'd2; end
            S_MEM_RD: begin
                mem_req = 1'b1;  mem_size = ls_size;  mem_unsigned = ls_uns;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;  mem_we = 1'b1;  mem_size = ls_size;
            end
            S_MEM_WB:   begin reg_we = 1'b1;  mem_to_reg = 1'b1; end
            S_BRANCH: begin
                alu_src_a = 1'b1;  alu_op = ALU_SUBU;  pc_src = 2'd1;
                pc_we = (opcode == OP_BNE) ? !alu_zero : alu_zero;
            end
            S_JUMP:     begin pc_we = 1'b1;  pc_src = 2'd2; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: each instruction is expanded into its
// expected per-cycle control trace, which is then replayed against the DUT.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       pc_we, ir_we, mem_req, mem_we, mem_unsigned, alu_src_a, imm_zext;
    logic       reg_we, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src, mem_size, alu_src_b;
    logic [3:0] alu_op;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_req(mem_req),
        .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal)
    );

    typedef struct packed {
        logic       pc_we;  logic [1:0] pc_src;  logic ir_we;
        logic       mem_req; logic mem_we; logic [1:0] mem_size; logic mem_uns;
        logic       a;  logic [1:0] b;  logic zext;  logic [3:0] alu;
        logic       reg_we; logic reg_dst; logic m2r; logic ill;
    } outs_t;

    typedef struct packed {
        logic  rdy;
        logic  z;
        outs_t e;
    } step_t;

    outs_t got;
    assign got = '{pc_we, pc_src, ir_we, mem_req, mem_we, mem_size, mem_unsigned,
                   alu_src_a, alu_src_b, imm_zext, alu_op, reg_we, reg_dst,
                   mem_to_reg, illegal};

    localparam logic [3:0] A_ADDU = 4'd0, A_SUBU = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7,
                           A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10, A_LUI = 4'd11;

    // Instruction tables (MIPS encodings)
    logic [5:0] r_fn  [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                               6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [3:0] r_alu [14] = '{A_SLL, A_SRL, A_SRA, A_SLL, A_SRL, A_SRA, A_ADDU,
                               A_SUBU, A_AND, A_OR, A_XOR, A_NOR, A_SLT, A_SLTU};
    logic [5:0] i_op  [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [3:0] i_alu [7]  = '{A_ADDU, A_SLT, A_SLTU, A_AND, A_OR, A_XOR, A_LUI};
    logic       i_zx  [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0] m_op  [8]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    logic       m_ld  [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] m_sz  [8]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    logic       m_un  [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    int unsigned n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Build the expected trace for one instruction and replay it.
    // stop_at >= 0 truncates the replay after that many cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z,
                             input int stop_at, input string name);
        step_t tr[$];
        outs_t o;
        int cls = 0;   // 0 illegal 1 R 2 I 3 mem 4 branch 5 jump
        logic [3:0] alu = A_ADDU;
        logic zx = 1'b0, ld = 1'b0, un = 1'b0;
        logic [1:0] sz = 2'd0;
        int lim;

        if (op == 6'h00) begin
            for (int i = 0; i < 14; i++) if (r_fn[i] == fn) begin cls = 1; alu = r_alu[i]; end
        end else begin
            for (int i = 0; i < 7; i++) if (i_op[i] == op) begin cls = 2; alu = i_alu[i]; zx = i_zx[i]; end
            for (int i = 0; i < 8; i++) if (m_op[i] == op) begin cls = 3; ld = m_ld[i]; sz = m_sz[i]; un = m_un[i]; end
            if (op == 6'h04 || op == 6'h05) cls = 4;
            if (op == 6'h02) cls = 5;
        end

        o = '0; o.mem_req = 1'b1; o.b = 2'd1; o.mem_size = 2'd2;
        for (int i = 0; i < fw; i++) tr.push_back('{1'b0, rbit(), o});
        o.ir_we = 1'b1; o.pc_we = 1'b1;
        tr.push_back('{1'b1, rbit(), o});

        o = '0; o.b = 2'd3; o.ill = (cls == 0);
        tr.push_back('{rbit(), rbit(), o});

        case (cls)
            1: begin
                o = '0; o.a = 1'b1; o.alu = alu;          tr.push_back('{rbit(), rbit(), o});
                o = '0; o.reg_we = 1'b1; o.reg_dst = 1'b1; tr.push_back('{rbit(), rbit(), o});
            end
            2: begin
                o = '0; o.a = 1'b1; o.b = 2'd2; o.alu = alu; o.zext = zx; tr.push_back('{rbit(), rbit(), o});
                o = '0; o.reg_we = 1'b1;                                  tr.push_back('{rbit(), rbit(), o});
            end
            3: begin
                o = '0; o.a = 1'b1; o.b = 2'd2; tr.push_back('{rbit(), rbit(), o});
                o = '0; o.mem_req = 1'b1; o.mem_we = !ld; o.mem_size = sz; o.mem_uns = un;
                for (int i = 0; i < mw; i++) tr.push_back('{1'b0, rbit(), o});
                tr.push_back('{1'b1, rbit(), o});
                if (ld) begin
                    o = '0; o.reg_we = 1'b1; o.m2r = 1'b1; tr.push_back('{rbit(), rbit(), o});
                end
            end
            4: begin
                o = '0; o.a = 1'b1; o.alu = A_SUBU; o.pc_src = 2'd1;
                o.pc_we = (op == 6'h05) ? !z : z;
                tr.push_back('{rbit(), z, o});
            end
            5: begin
                o = '0; o.pc_we = 1'b1; o.pc_src = 2'd2; tr.push_back('{rbit(), rbit(), o});
            end
            default: ;
        endcase

        lim = (stop_at >= 0) ? stop_at : tr.size();
        for (int k = 0; k < lim; k++) begin
            #1;
            opcode = op; funct = fn;
            mem_ready = tr[k].rdy; alu_zero = tr[k].z;
            #1;
            check($sformatf("%s_c%0d", name, k), 32'(got), 32'(tr[k].e));
            @(posedge clk);
        end
    endtask

    task automatic rand_instr(input int idx);
        logic [5:0] op, fn;
        logic known;
        int c;
        fn = 6'($urandom);
        c = $urandom_range(0, 7);
        case (c)
            0, 1: begin op = 6'h00; fn = r_fn[$urandom_range(0, 13)]; end
            2: begin
                op = 6'h00;
                do begin
                    fn = 6'($urandom); known = 1'b0;
                    for (int i = 0; i < 14; i++) if (r_fn[i] == fn) known = 1'b1;
                end while (known);
            end
            3: op = i_op[$urandom_range(0, 6)];
            4, 5: op = m_op[$urandom_range(0, 7)];
            6: op = ($urandom_range(0, 2) == 0) ? 6'h02 : (rbit() ? 6'h05 : 6'h04);
            default: begin
                do begin
                    op = 6'($urandom);
                    known = (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h05);
                    for (int i = 0; i < 7; i++) if (i_op[i] == op) known = 1'b1;
                    for (int i = 0; i < 8; i++) if (m_op[i] == op) known = 1'b1;
                end while (known);
            end
        endcase
        run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), -1,
                  $sformatf("rnd%0d", idx));
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0; opcode = '0; funct = '0;
        #1 check("rst_low", 32'(got), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_hold", 32'(got), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_state", 32'(got), 32'd0);
        @(posedge clk);

        run_instr(6'h00, 6'h21, 0, 0, 1'b0, -1, "addu");
        run_instr(6'h24, 6'h00, 0, 3, 1'b0, -1, "lbu");
        run_instr(6'h05, 6'h00, 0, 0, 1'b1, -1, "bne_z1");
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, -1, "bne_z0");
        run_instr(6'h04, 6'h00, 1, 0, 1'b1, -1, "beq_z1");
        run_instr(6'h00, 6'h3F, 0, 0, 1'b0, -1, "ill_fn");
        run_instr(6'h02, 6'h00, 2, 0, 1'b0, -1, "jump");
        run_instr(6'h2B, 6'h00, 0, 2, 1'b0, -1, "sw");

        // Reset asserted while a store waits on memory
        run_instr(6'h29, 6'h00, 0, 5, 1'b0, 5, "sh_abort");
        #1 mem_ready = 1'b0;
        #1 check("wr_wait_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1 check("wr_abort_req", 32'(mem_req), 32'd0);
        check("wr_abort_all", 32'(got), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("wr_abort_rst", 32'(got), 32'd0);
        @(posedge clk);
        run_instr(6'h00, 6'h27, 0, 0, 1'b0, -1, "after_abort");

        for (int n = 0; n < 300; n++) rand_instr(n);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
